// File: rtl/backtrack_replayer.sv
// ---------------------------------------------------------------------------
// backtrack_replayer
//
// Sits between the steering logic and the servo/SPI driver.
//
// In normal driving (RECORD), the live X/Y servo commands are passed through
// with a latency of one cycle. Once every SAMPLE_DIV cycles they are also
// pushed into a circular LIFO. When the LIFO is full, a push overwrites the
// oldest entry.
//
// While backtrack_active is high, the recorded positions are replayed
// newest-first at the same rate, so the vehicle retraces its path (REPLAY).
// When the LIFO runs dry, the last value is held (HOLD). When
// backtrack_active drops, the block returns to RECORD. Entries that were not
// replayed are kept.
//
// Optional feature, controlled by the BACKTRACK_MIRROR_EN macro:
//   BACKTRACK_MIRROR_EN defined : a replayed X is output as (2**DATA_W-1) - X,
//                                 which mirrors the steering for reversing.
//                                 Y and the stored data are not changed.
//   not defined                 : replayed values are output exactly as stored.
//
// Ports:
//   clk               in   1                system clock, rising edge
//   rst               in   1                asynchronous reset, active high
//   x_pos_in          in   DATA_W           live X position command
//   y_pos_in          in   DATA_W           live Y position command
//   backtrack_active  in   1                high for the backtrack window
//   x_pos_out         out  DATA_W           X command to the servo driver
//   y_pos_out         out  DATA_W           Y command to the servo driver
//   replay_active     out  1                high in REPLAY or HOLD
//   buf_count         out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module backtrack_replayer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 64,         // power of two, >= 2
  parameter int SAMPLE_DIV = 10_000_000  // clk cycles per record/replay step
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        x_pos_in,
  input  logic [DATA_W-1:0]        y_pos_in,
  input  logic                     backtrack_active,
  output logic [DATA_W-1:0]        x_pos_out,
  output logic [DATA_W-1:0]        y_pos_out,
  output logic                     replay_active,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] X_MAX   = '1;

  localparam logic [1:0] ST_RECORD = 2'd0;
  localparam logic [1:0] ST_REPLAY = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [DATA_W-1:0] x_out_q,   x_out_d;
  logic [DATA_W-1:0] y_out_q,   y_out_d;
  logic              replay_q,  replay_d;
  logic              bt_q;

  logic              tick;
  logic              rise;
  logic              fall;
  logic              push;
  logic              pop;

  // Each entry holds X in the upper half and Y in the lower half.
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rd_entry;
  logic [DATA_W-1:0]   rd_x;
  logic [DATA_W-1:0]   rd_y;
  logic [DATA_W-1:0]   pop_x;

  assign tick = (div_q == DIV_MAX);
  assign rise = backtrack_active & ~bt_q;
  assign fall = ~backtrack_active & bt_q;

  // The newest entry is always the one just below the write pointer.
  // The subtraction wraps naturally modulo DEPTH.
  assign rd_entry = mem[wr_ptr_q - PTR_W'(1)];
  assign rd_x     = rd_entry[2*DATA_W-1:DATA_W];
  assign rd_y     = rd_entry[DATA_W-1:0];

`ifdef BACKTRACK_MIRROR_EN
  assign pop_x = X_MAX - rd_x;
`else
  assign pop_x = rd_x;
`endif

  always_comb begin
    // NOTE: every signal gets a default first, so that no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    push     = 1'b0;
    pop      = 1'b0;

    case (state_q)
      ST_RECORD: begin
        if (rise) begin
          // The first pop happens on the rise edge itself.
          // A rise on a tick cycle therefore takes priority over the push.
          if (count_q != '0) begin
            state_d = ST_REPLAY;
            pop     = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          x_out_d = x_pos_in;
          y_out_d = y_pos_in;
          push    = tick;
        end
      end
      ST_REPLAY: begin
        if (fall) begin
          state_d = ST_RECORD;
        end else if (tick) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fall) state_d = ST_RECORD;
      end
      default: state_d = ST_RECORD;
    endcase

    if (push) begin
      // When the buffer is full, wr_ptr already points at the oldest entry.
      // The write therefore overwrites it, and the count stays saturated.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q != FULL) count_d = count_q + CNT_W'(1);
    end

    if (pop) begin
      x_out_d  = pop_x;
      y_out_d  = rd_y;
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end

    // The sample phase restarts on every state change, so the first replay
    // step comes a full SAMPLE_DIV cycles after the rise edge.
    if ((state_d != state_q) || tick) div_d = '0;
    else                              div_d = div_q + DIV_W'(1);

    replay_d = (state_d != ST_RECORD);
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples the pre-edge values regardless of the order of statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RECORD;
      div_q    <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      replay_q <= 1'b0;
      bt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      replay_q <= replay_d;
      bt_q     <= backtrack_active;
    end
  end

  // NOTE: the storage array has no reset. An entry is only ever read after it
  // has been written, because count_q guards every pop, so clearing the array
  // on reset would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {x_pos_in, y_pos_in};
  end

  assign x_pos_out     = x_out_q;
  assign y_pos_out     = y_out_q;
  assign replay_active = replay_q;
  assign buf_count     = count_q;

endmodule

// File: tb/tb_backtrack_replayer.sv
// ---------------------------------------------------------------------------
// tb_backtrack_replayer
//
// Self-checking bench for backtrack_replayer, built with DATA_W=8, DEPTH=4
// and SAMPLE_DIV=4.
//
// The reference model keeps the recorded path in a queue:
//   - a record appends to the back and drops the front once DEPTH is exceeded;
//   - a replay takes entries from the back.
// A plain integer cycle count provides the sample rate.
//
// The bench runs directed scenarios first, then a randomized run with
// occasional resets. Honours BACKTRACK_MIRROR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_backtrack_replayer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] x_in;
  logic [DW-1:0] y_in;
  logic          bt;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic          ra;
  logic [2:0]    cnt;

  backtrack_replayer #(.DATA_W(DW), .DEPTH(DEPTH), .SAMPLE_DIV(DIV)) dut (
    .clk              (clk),
    .rst              (rst),
    .x_pos_in         (x_in),
    .y_pos_in         (y_in),
    .backtrack_active (bt),
    .x_pos_out        (x_out),
    .y_pos_out        (y_out),
    .replay_active    (ra),
    .buf_count        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic [DW-1:0] x; logic [DW-1:0] y; } entry_t;
  typedef enum { M_REC, M_REP, M_HOLD } mode_t;

  entry_t        path[$];
  mode_t         mode;
  int            phase;
  bit            bt_prev;
  logic [DW-1:0] ex;
  logic [DW-1:0] ey;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] replay_x(input logic [DW-1:0] stored);
`ifdef BACKTRACK_MIRROR_EN
    return 8'hFF - stored;
`else
    return stored;
`endif
  endfunction

  task automatic model_reset();
    path.delete();
    mode    = M_REC;
    phase   = 0;
    bt_prev = 1'b0;
    ex      = '0;
    ey      = '0;
  endtask

  task automatic model_pop();
    entry_t e;
    e  = path.pop_back();
    ex = replay_x(e.x);
    ey = e.y;
  endtask

  // Advances the model by one clock, using the inputs seen at the edge.
  task automatic model_step(input logic [DW-1:0] xi, input logic [DW-1:0] yi, input bit b);
    bit    sample;
    mode_t nxt;
    entry_t e;
    sample = (phase == DIV - 1);
    nxt    = mode;
    case (mode)
      M_REC: begin
        if (b && !bt_prev) begin
          if (path.size() > 0) begin
            model_pop();
            nxt = M_REP;
          end else begin
            nxt = M_HOLD;
          end
        end else begin
          ex = xi;
          ey = yi;
          if (sample) begin
            e.x = xi;
            e.y = yi;
            path.push_back(e);
            if (path.size() > DEPTH) void'(path.pop_front());
          end
        end
      end
      M_REP: begin
        if (!b && bt_prev) begin
          nxt = M_REC;
        end else if (sample) begin
          if (path.size() > 0) model_pop();
          else                 nxt = M_HOLD;
        end
      end
      default: begin
        if (!b && bt_prev) nxt = M_REC;
      end
    endcase
    phase   = (nxt != mode || sample) ? 0 : phase + 1;
    mode    = nxt;
    bt_prev = b;
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then
  // compare once the DUT outputs have settled.
  task automatic step(input logic [DW-1:0] xi, input logic [DW-1:0] yi, input bit b);
    x_in = xi;
    y_in = yi;
    bt   = b;
    @(posedge clk);
    model_step(xi, yi, b);
    #1;
    check("x_pos_out", 32'(x_out), 32'(ex));
    check("y_pos_out", 32'(y_out), 32'(ey));
    check("replay_active", 32'(ra), 32'(mode != M_REC));
    check("buf_count", 32'(cnt), 32'(path.size()));
  endtask

  // Asserts reset away from any clock edge.
  // The outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_x", 32'(x_out), 32'h0);
    check("rst_y", 32'(y_out), 32'h0);
    check("rst_ra", 32'(ra), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    x_in = '0;
    y_in = '0;
    bt   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-run.
    for (int i = 0; i < 7; i++) step(8'(i + 3), 8'(i + 9), 1'b0);
    do_reset();

    // A steady input is recorded three times over three ticks.
    for (int i = 0; i < 3 * DIV; i++) step(8'h10, 8'h20, 1'b0);
    check("t2_count", 32'(cnt), 32'd3);

    // Record 1,2,3, then replay them newest-first and end in HOLD.
    do_reset();
    for (int v = 1; v <= 3; v++)
      for (int i = 0; i < DIV; i++) step(8'(v), 8'(v + 8'h40), 1'b0);
    step(8'hAA, 8'hBB, 1'b1);
    check("t3_pop3", 32'(x_out), 32'(replay_x(8'd3)));
    for (int i = 0; i < DIV; i++) step(8'hAA, 8'hBB, 1'b1);
    check("t3_pop2", 32'(x_out), 32'(replay_x(8'd2)));
    for (int i = 0; i < DIV; i++) step(8'hAA, 8'hBB, 1'b1);
    check("t3_pop1", 32'(x_out), 32'(replay_x(8'd1)));
    for (int i = 0; i < DIV; i++) step(8'hAA, 8'hBB, 1'b1);
    check("t3_hold_x", 32'(x_out), 32'(replay_x(8'd1)));
    check("t3_hold_cnt", 32'(cnt), 32'd0);
    check("t3_hold_ra", 32'(ra), 32'd1);

    // Six records saturate the count; replay returns the newest four.
    do_reset();
    for (int v = 1; v <= 6; v++)
      for (int i = 0; i < DIV; i++) step(8'(v), 8'(v), 1'b0);
    check("t4_sat", 32'(cnt), 32'd4);
    step(8'h00, 8'h00, 1'b1);
    check("t4_pop6", 32'(x_out), 32'(replay_x(8'd6)));
    for (int i = 0; i < 3 * DIV; i++) step(8'h00, 8'h00, 1'b1);
    check("t4_pop3", 32'(x_out), 32'(replay_x(8'd3)));

    // Drop backtrack after two pops.
    // The remaining entries survive for the next replay.
    do_reset();
    for (int v = 1; v <= 4; v++)
      for (int i = 0; i < DIV; i++) step(8'(v), 8'(v + 8'h80), 1'b0);
    for (int i = 0; i < DIV + 1; i++) step(8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b0);
    check("t5_kept", 32'(cnt), 32'd2);
    check("t5_ra", 32'(ra), 32'd0);
    step(8'h77, 8'h78, 1'b0);
    check("t5_pass", 32'(x_out), 32'h77);
    step(8'h00, 8'h00, 1'b1);
    check("t5_pop2", 32'(x_out), 32'(replay_x(8'd2)));
    for (int i = 0; i < DIV; i++) step(8'h00, 8'h00, 1'b1);
    check("t5_pop1", 32'(x_out), 32'(replay_x(8'd1)));

    // A rise with an empty buffer goes straight to HOLD; then check mirroring.
    do_reset();
    step(8'h55, 8'h66, 1'b1);
    check("t6_ra", 32'(ra), 32'd1);
    step(8'h99, 8'h98, 1'b1);
    check("t6_frozen", 32'(x_out), 32'h0);
    step(8'h99, 8'h98, 1'b0);
    for (int i = 0; i < DIV; i++) step(8'h10, 8'h20, 1'b0);
    step(8'h00, 8'h00, 1'b1);
`ifdef BACKTRACK_MIRROR_EN
    check("t6_mirror", 32'(x_out), 32'hEF);
`else
    check("t6_plain", 32'(x_out), 32'h10);
`endif
    check("t6_y", 32'(y_out), 32'h20);

    // Randomized run: random inputs, occasional backtrack toggles and resets.
    do_reset();
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) b = ~b;
        if ($urandom_range(499) == 0) do_reset();
        step(8'($urandom), 8'($urandom), b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
